// File: rtl/ula_control_fsm_pkg.sv
// Shared constants for the multicycle ULA control unit: opcodes, functs,
// ULAControl and ALUOp encodings, 4-bit state encodings and per-state
// control decode.
package ula_control_fsm_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned UC_W  = 3;
  localparam int unsigned AOP_W = 2;
  localparam int unsigned ST_W  = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [UC_W-1:0] UC_AND = 3'b000;
  localparam logic [UC_W-1:0] UC_OR  = 3'b001;
  localparam logic [UC_W-1:0] UC_ADD = 3'b010;
  localparam logic [UC_W-1:0] UC_NOR = 3'b011;
  localparam logic [UC_W-1:0] UC_SUB = 3'b110;
  localparam logic [UC_W-1:0] UC_SLT = 3'b111;

  localparam logic [AOP_W-1:0] AOP_ADD   = 2'b00;
  localparam logic [AOP_W-1:0] AOP_SUB   = 2'b01;
  localparam logic [AOP_W-1:0] AOP_FUNCT = 2'b10;

  localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] S_FETCH  = 4'd1;
  localparam logic [ST_W-1:0] S_DECODE = 4'd2;
  localparam logic [ST_W-1:0] S_MEMADR = 4'd3;
  localparam logic [ST_W-1:0] S_MEMRD  = 4'd4;
  localparam logic [ST_W-1:0] S_MEMWB  = 4'd5;
  localparam logic [ST_W-1:0] S_MEMWR  = 4'd6;
  localparam logic [ST_W-1:0] S_EXEC   = 4'd7;
  localparam logic [ST_W-1:0] S_ALUWB  = 4'd8;
  localparam logic [ST_W-1:0] S_BRANCH = 4'd9;
  localparam logic [ST_W-1:0] S_ADDIEX = 4'd10;
  localparam logic [ST_W-1:0] S_ADDIWB = 4'd11;
  localparam logic [ST_W-1:0] S_JUMP   = 4'd12;
  localparam logic [ST_W-1:0] S_TRAP   = 4'd13;
  localparam logic [ST_W-1:0] S_FWAIT  = 4'd14;  // step-mode hold before FETCH

  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       memwrite;
    logic       iord;
    logic       branch;
    logic       done;
  } ctrl_t;

  // Moore datapath controls for a state; anything not listed is 0
  function automatic ctrl_t state_ctrl(input logic [ST_W-1:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
      S_EXEC:   c.alusrca = 1'b1;
      S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin c.alusrca = 1'b1; c.pcsrc = 2'b01; c.branch = 1'b1; c.done = 1'b1; end
      S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB: begin c.regwrite = 1'b1; c.done = 1'b1; end
      S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  // ALU operation class for a state
  function automatic logic [AOP_W-1:0] state_aluop(input logic [ST_W-1:0] st);
    logic [AOP_W-1:0] a;
    a = AOP_ADD;
    if (st == S_EXEC)   a = AOP_FUNCT;
    if (st == S_BRANCH) a = AOP_SUB;
    return a;
  endfunction

endpackage

// File: rtl/ula_control_fsm_if.sv
// Control-unit bus: IR fields and Z in, datapath controls out.
// Optional trap flag exists only when ILLEGAL_OP_TRAP_EN is defined.
interface ula_control_fsm_if;
  import ula_control_fsm_pkg::*;

  logic             run;
  logic             step;
  logic [OP_W-1:0]  opcode;
  logic [FN_W-1:0]  funct;
  logic             Z;
  logic [UC_W-1:0]  ULAControl;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSrc;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             MemWrite;
  logic             IorD;
  logic             instr_done;
  logic             pc_en_c;
`ifdef ILLEGAL_OP_TRAP_EN
  logic             trap;
`endif

  modport master (
    input  run, step, opcode, funct, Z,
    output ULAControl, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, MemWrite, IorD, instr_done, pc_en_c
`ifdef ILLEGAL_OP_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output run, step, opcode, funct, Z,
    input  ULAControl, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, MemWrite, IorD, instr_done, pc_en_c
`ifdef ILLEGAL_OP_TRAP_EN
    , input trap
`endif
  );

endinterface

// File: rtl/ula_control_fsm_decoder.sv
// Combinational {ALUOp, funct} -> ULAControl. Unknown functs map to ADD;
// with ILLEGAL_OP_TRAP_EN they are also flagged as illegal.
module ula_control_fsm_decoder
  import ula_control_fsm_pkg::*;
(
  input  logic [AOP_W-1:0] aluop,
  input  logic [FN_W-1:0]  funct,
  output logic [UC_W-1:0]  ula_control
`ifdef ILLEGAL_OP_TRAP_EN
  , output logic           illegal
`endif
);

  // ALU operation select
  always_comb begin
    ula_control = UC_ADD;
    case (aluop)
      AOP_SUB: ula_control = UC_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  ula_control = UC_ADD;
          FN_SUB:  ula_control = UC_SUB;
          FN_AND:  ula_control = UC_AND;
          FN_OR:   ula_control = UC_OR;
          FN_NOR:  ula_control = UC_NOR;
          FN_SLT:  ula_control = UC_SLT;
          default: ula_control = UC_ADD;
        endcase
      end
      default: ula_control = UC_ADD;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = (aluop == AOP_FUNCT) &&
                   !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT});
`endif

endmodule

// File: rtl/ula_control_fsm.sv
// Multicycle control FSM for the 8-bit ULA datapath. Outputs are registered
// from the next state so each state's controls appear while in that state.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcode/funct -> TRAP).
module ula_control_fsm
  import ula_control_fsm_pkg::*;
#(
  parameter bit STEP_MODE = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  ula_control_fsm_if.master bus
);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_next;
  logic [ST_W-1:0]  fetch_st;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_next;
  logic [AOP_W-1:0] aluop_next;
  logic [UC_W-1:0]  ula_q;
  logic [UC_W-1:0]  ula_next;
`ifdef ILLEGAL_OP_TRAP_EN
  logic             illegal_next;
  logic             illegal_q;
  logic             trap_q;
`endif

  assign fetch_st = STEP_MODE ? S_FWAIT : S_FETCH;

  ula_control_fsm_decoder u_dec (
    .aluop       (aluop_next),
    .funct       (bus.funct),
    .ula_control (ula_next)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal   (illegal_next)
`endif
  );

  // Next-state and next-output decode
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:  if (bus.run) state_next = fetch_st;
      S_FWAIT: begin
        if (!bus.run)     state_next = S_IDLE;
        else if (bus.step) state_next = S_FETCH;
      end
      S_FETCH: state_next = bus.run ? S_DECODE : S_IDLE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = fetch_st;
`endif
        endcase
      end
      S_MEMADR: state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_EXEC:   state_next = illegal_q ? S_TRAP : S_ALUWB;
`else
      S_EXEC:   state_next = S_ALUWB;
`endif
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = fetch_st;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
    ctrl_next  = state_ctrl(state_next);
    aluop_next = state_aluop(state_next);
  end

  // State and registered control outputs; reset clears every enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      ula_q   <= UC_ADD;
    end else begin
      state_q <= state_next;
      ctrl_q  <= ctrl_next;
      ula_q   <= ula_next;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  // Funct legality captured on entry to EXEC; sticky trap flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      illegal_q <= illegal_next;
      trap_q    <= (state_next == S_TRAP);
    end
  end
  assign bus.trap = trap_q;
`endif

  assign bus.ULAControl = ula_q;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.PCSrc      = ctrl_q.pcsrc;
  assign bus.PCWrite    = ctrl_q.pcwrite;
  assign bus.IRWrite    = ctrl_q.irwrite;
  assign bus.RegWrite   = ctrl_q.regwrite;
  assign bus.RegDst     = ctrl_q.regdst;
  assign bus.MemtoReg   = ctrl_q.memtoreg;
  assign bus.MemWrite   = ctrl_q.memwrite;
  assign bus.IorD       = ctrl_q.iord;
  assign bus.instr_done = ctrl_q.done;
  // PC strobe: unconditional write, or taken branch on the live Z flag
  assign bus.pc_en_c    = ctrl_q.pcwrite | (ctrl_q.branch & bus.Z);

endmodule

// File: tb/tb_ula_control_fsm.sv
// Self-checking bench for ula_control_fsm: per-instruction expected control
// sequences built from the instruction-level behaviour, random back-to-back
// instruction streams, run stop, reset abort.
module tb_ula_control_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_control_fsm_if bus ();

  ula_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] uc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       memw;
    logic       iord;
    logic       done;
    logic       pcen;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b100111, 6'b101010};

  function automatic vec_t actual();
    vec_t v;
    v = {bus.ULAControl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.PCWrite,
         bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.MemWrite,
         bus.IorD, bus.instr_done, bus.pc_en_c};
    return v;
  endfunction

  // Quiet vector: every enable low, ALU on ADD
  function automatic vec_t quiet();
    vec_t v;
    v = '0;
    v.uc = 3'b010;
    return v;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100111: return 3'b011;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected cycle-by-cycle controls of one instruction, starting at fetch
  function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn,
                                    input logic zb);
    vec_t v;
    exp_q.delete();
    v = quiet(); v.srcb = 2'b01; v.irw = 1'b1; v.pcw = 1'b1; v.pcen = 1'b1;
    exp_q.push_back(v);
    v = quiet(); v.srcb = 2'b11;
    exp_q.push_back(v);
    case (op)
      6'b100011, 6'b101011: begin
        v = quiet(); v.srca = 1'b1; v.srcb = 2'b10;
        exp_q.push_back(v);
        if (op == 6'b100011) begin
          v = quiet(); v.iord = 1'b1;
          exp_q.push_back(v);
          v = quiet(); v.m2r = 1'b1; v.regw = 1'b1; v.done = 1'b1;
          exp_q.push_back(v);
        end else begin
          v = quiet(); v.iord = 1'b1; v.memw = 1'b1; v.done = 1'b1;
          exp_q.push_back(v);
        end
      end
      6'b000000: begin
        v = quiet(); v.srca = 1'b1; v.uc = ref_alu(fn);
        exp_q.push_back(v);
        v = quiet(); v.regdst = 1'b1; v.regw = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
      end
      6'b000100: begin
        v = quiet(); v.srca = 1'b1; v.uc = 3'b110; v.pcsrc = 2'b01;
        v.done = 1'b1; v.pcen = zb;
        exp_q.push_back(v);
      end
      6'b001000: begin
        v = quiet(); v.srca = 1'b1; v.srcb = 2'b10;
        exp_q.push_back(v);
        v = quiet(); v.regw = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
      end
      6'b000010: begin
        v = quiet(); v.pcsrc = 2'b10; v.pcw = 1'b1; v.done = 1'b1; v.pcen = 1'b1;
        exp_q.push_back(v);
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction from its fetch cycle; optional run drop or reset abort
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zb, input string name,
                           input bit drop_run, input int abort_at);
    vec_t act;
    build_seq(op, fn, zb);
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (drop_run && i == 1) bus.run = 1'b0;
      bus.Z = (op == 6'b000100 && i == 2) ? zb : 1'($urandom);
      #1;
      act = actual();
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: actual=%h expected=%h", name, i, act, exp_q[i]);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vec_t act;
    rst_n = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.Z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    act = actual();
    checks++;
    if (act !== quiet()) begin
      errors++;
      $display("FAIL reset_idle: actual=%h expected=%h", act, quiet());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    act = actual();
    checks++;
    if (act !== quiet()) begin
      errors++;
      $display("FAIL idle_hold_run0: actual=%h expected=%h", act, quiet());
    end
    bus.run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 6'b101010, 1'b0, "r_slt", 1'b0, -1);
    run_instr(6'b000000, 6'b100100, 1'b1, "r_and", 1'b0, -1);
    run_instr(6'b000000, 6'b100111, 1'b0, "r_nor", 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'($urandom), 1'b1, "beq_taken", 1'b0, -1);
    run_instr(6'b000100, 6'($urandom), 1'b0, "beq_not_taken", 1'b0, -1);
  endtask

  task automatic test_mem();
    run_instr(6'b100011, 6'($urandom), 1'b0, "lw", 1'b0, -1);
    run_instr(6'b101011, 6'($urandom), 1'b0, "sw", 1'b0, -1);
    run_instr(6'b001000, 6'($urandom), 1'b0, "addi", 1'b0, -1);
    run_instr(6'b000010, 6'($urandom), 1'b0, "jump", 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b000000, 1'b0, "illegal_op", 1'b0, -1);
    run_instr(6'b000000, 6'b111111, 1'b0, "unknown_funct", 1'b0, -1);
    run_instr(6'b000000, 6'b100010, 1'b0, "after_illegal", 1'b0, -1);
  endtask

  task automatic test_run_stop();
    vec_t act;
    vec_t f;
    run_instr(6'b000000, 6'b100101, 1'b0, "run_drop_instr", 1'b1, -1);
    f = quiet(); f.srcb = 2'b01; f.irw = 1'b1; f.pcw = 1'b1; f.pcen = 1'b1;
    act = actual();
    checks++;
    if (act !== f) begin
      errors++;
      $display("FAIL run_stop_fetch: actual=%h expected=%h", act, f);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      act = actual();
      checks++;
      if (act !== quiet()) begin
        errors++;
        $display("FAIL run_stop_idle%0d: actual=%h expected=%h", k, act, quiet());
      end
    end
    bus.run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    vec_t act;
    run_instr(6'b101011, 6'b000000, 1'b0, "sw_abort", 1'b0, 3);
    act = actual();
    checks++;
    if (act !== quiet()) begin
      errors++;
      $display("FAIL reset_in_memwr: actual=%h expected=%h", act, quiet());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(6'b100011, 6'b000000, 1'b0, "lw_after_abort", 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic [5:0] fn;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), "random", 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_mem();
    test_illegal();
    test_run_stop();
    test_reset_midflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
